sw_alloc_rr: RTL and testbench
==============================

Name: sw_alloc_rr

Overview:
- Round-robin wormhole switch allocator: shares one output-port FIFO write interface between NUM_IN input ports.
- Grants the output on a head flit and holds it for the whole packet until the tail flit is written; the next packet is then arbitrated round-robin.
- Sits between the per-input buffers and the output FIFO of a router port. The flit datapath is a zero-latency combinational mux; arbitration state is registered.

Parameters:
- NUM_IN, 4, number of requesting inputs (2..8)
- DATA_W, 32, flit width; flit type field = data[DATA_W-1:DATA_W-2]
- CNT_W, 16, width of the forwarded-packet counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_i  in  NUM_IN  per-input flit valid
- data_i  in  NUM_IN*DATA_W  per-input flit data, input i at [i*DATA_W +: DATA_W]
- ready_o  out  NUM_IN  per-input flit accepted this cycle (when valid)
- fifo_full_i  in  1  output FIFO full
- fifo_wr_o  out  1  output FIFO write strobe
- fifo_wr_data_o  out  DATA_W  output FIFO write data
- busy_o  out  1  a packet currently holds the output
- owner_o  out  clog2(NUM_IN)  index of the locked input (valid when busy_o=1)
- drop_o  out  1  one-cycle pulse: stray non-head flit discarded
- pkt_cnt_o  out  CNT_W  count of tail flits written, wraps

Behaviour:
- Flit types: 2'b00 head, 2'b11 tail, 2'b01/2'b10 body. Every packet has at least 2 flits (head and tail are distinct flits).
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, owner=0, pkt_cnt=0.
  - Outputs: busy_o=0, owner_o=0, drop_o=0, pkt_cnt_o=0, fifo_wr_o=0, fifo_wr_data_o=0, ready_o=0.
- Reset mid-packet: lock abandoned, no flit written; the remaining flits of that packet are later treated as strays in IDLE.
- State IDLE:
  - Candidates = inputs with valid_i=1 and head-type data.
  - Winner = first candidate at or after rr_ptr, searching upward with wrap.
  - If a winner exists and fifo_full_i=0: ready_o[win]=1, fifo_wr_o=1, fifo_wr_data_o=data_i[win], same cycle.
  - On that clock edge: state→LOCKED, owner←win, rr_ptr←(win+1) mod NUM_IN.
  - If fifo_full_i=1: no ready, no write, no state change; rr_ptr is held, so the same winner is chosen when space appears.
- Stray flits in IDLE:
  - If no head candidate exists, the lowest-index input presenting a valid non-head flit is consumed: ready_o=1, no FIFO write, drop_o=1 that cycle.
  - This applies regardless of fifo_full_i and prevents head-of-line deadlock.
  - A head candidate always takes priority over stray discard.
- State LOCKED:
  - Only input owner may proceed: ready_o[owner]=~fifo_full_i. All other ready_o bits are 0.
  - fifo_wr_o = valid_i[owner] & ~fifo_full_i; fifo_wr_data_o = data_i[owner].
  - Tail written → state→IDLE and pkt_cnt +1 (wraps at 2^CNT_W).
  - A head flit from owner while LOCKED is forwarded as body; no relock, no error.
- fifo_wr_data_o is 0 whenever fifo_wr_o=0.
- Handshake:
  - ready_o may assert without valid_i (LOCKED) and is independent of the flit value.
  - A transfer occurs when valid_i & ready_o.
  - Upstream must hold data stable while valid and not ready.
- Throughput:
  - One flit per cycle; a tail then the next head (any input) may be written on consecutive cycles.
  - No cycle is lost between packets.
- busy_o = (state==LOCKED); owner_o is registered.
- Zero-cycle latency data to FIFO; all state is registered on the rising clk.

Test Plan:
- Single packet: input 2 sends head(00), body(01), tail(11) with fifo_full_i=0 → 3 consecutive fifo_wr_o, data equal to input 2; busy_o=1 for 2 cycles; owner_o=2; pkt_cnt_o=1.
- Round-robin fairness: all 4 inputs continuously offer 2-flit packets from reset → packet grant order 0,1,2,3,0,1; never 0 twice in a row while others are waiting.
- Backpressure: lock input 1, then assert fifo_full_i for 5 cycles mid-packet → ready_o=0 and fifo_wr_o=0 for those 5 cycles; no flit lost or duplicated; a head on input 3 is not granted until input 1's tail is written.
- Stray flit: IDLE, only input 0 offers a body flit → ready_o[0]=1, fifo_wr_o=0, drop_o=1 for one cycle; a head on input 2 in the same cycle wins instead and input 0 stalls.
- Async reset mid-packet: assert rst while locked to input 3 → busy_o=0 and rr_ptr=0 immediately; after release, input 3's remaining body/tail flits are dropped (drop_o pulses) and a head on input 0 is granted.
- Counter wrap: with CNT_W=4, send 17 packets → pkt_cnt_o=1.

Source files
------------

// File: rtl/sw_alloc_rr.sv
// Round-robin wormhole switch allocator: grants one output FIFO to a single input for a whole
// packet (head to tail), with a combinational flit mux and registered arbitration state.
module sw_alloc_rr #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         valid_i,
  input  logic [NUM_IN*DATA_W-1:0]  data_i,
  output logic [NUM_IN-1:0]         ready_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_wr_o,
  output logic [DATA_W-1:0]         fifo_wr_data_o,
  output logic                      busy_o,
  output logic [$clog2(NUM_IN)-1:0] owner_o,
  output logic                      drop_o,
  output logic [CNT_W-1:0]          pkt_cnt_o
);

  localparam int unsigned IdxW = $clog2(NUM_IN);
  localparam logic [1:0] TypeHead = 2'b00;
  localparam logic [1:0] TypeTail = 2'b11;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [DATA_W-1:0] flit [NUM_IN];
  logic [NUM_IN-1:0] is_head;
  logic [NUM_IN-1:0] is_stray;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_flit
    assign flit[g]     = data_i[g*DATA_W +: DATA_W];
    assign is_head[g]  = valid_i[g] && (flit[g][DATA_W-1 -: 2] == TypeHead);
    assign is_stray[g] = valid_i[g] && (flit[g][DATA_W-1 -: 2] != TypeHead);
  end

  logic            head_found;
  logic [IdxW-1:0] win_idx;
  logic            stray_found;
  logic [IdxW-1:0] stray_idx;
  logic [IdxW-1:0] win_next;

  // Rotating search: first head at or after rr_ptr, wrapping at NUM_IN.
  always_comb begin
    int unsigned pos;
    int unsigned nxt;
    pos        = 0;
    head_found = 1'b0;
    win_idx    = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= NUM_IN) pos = pos - NUM_IN;
      if (!head_found && is_head[IdxW'(pos)]) begin
        head_found = 1'b1;
        win_idx    = IdxW'(pos);
      end
    end
    nxt = 32'(win_idx) + 1;
    if (nxt >= NUM_IN) nxt = 0;
    win_next = IdxW'(nxt);
  end

  always_comb begin
    stray_found = 1'b0;
    stray_idx   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (is_stray[k]) begin
        stray_found = 1'b1;
        stray_idx   = IdxW'(k);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    pkt_cnt_d      = pkt_cnt_q;
    ready_o        = '0;
    fifo_wr_o      = 1'b0;
    fifo_wr_data_o = '0;
    drop_o         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (head_found) begin
          if (!fifo_full_i) begin
            ready_o[win_idx] = 1'b1;
            fifo_wr_o        = 1'b1;
            fifo_wr_data_o   = flit[win_idx];
            state_d          = StLocked;
            owner_d          = win_idx;
            rr_ptr_d         = win_next;
          end
        end else if (stray_found) begin
          // Discard regardless of FIFO space so a stray cannot block its input forever.
          ready_o[stray_idx] = 1'b1;
          drop_o             = 1'b1;
        end
      end
      StLocked: begin
        ready_o[owner_q] = ~fifo_full_i;
        if (valid_i[owner_q] && !fifo_full_i) begin
          fifo_wr_o      = 1'b1;
          fifo_wr_data_o = flit[owner_q];
          if (flit[owner_q][DATA_W-1 -: 2] == TypeTail) begin
            state_d   = StIdle;
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase

    // Handshake outputs stay quiet while reset is held.
    if (rst) begin
      ready_o        = '0;
      fifo_wr_o      = 1'b0;
      fifo_wr_data_o = '0;
      drop_o         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign busy_o    = (state_q == StLocked);
  assign owner_o   = owner_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Scoreboard bench for sw_alloc_rr: directed flit streams push expected FIFO writes into a
// queue that a negedge monitor drains; control outputs are checked inline.
module tb_sw_alloc_rr;

  localparam logic [1:0] HD = 2'b00;
  localparam logic [1:0] BD = 2'b01;
  localparam logic [1:0] TL = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   valid_i;
  logic [127:0] data_i;
  logic [3:0]   ready_o;
  logic         fifo_full_i;
  logic         fifo_wr_o;
  logic [31:0]  fifo_wr_data_o;
  logic         busy_o;
  logic [1:0]   owner_o;
  logic         drop_o;
  logic [3:0]   pkt_cnt_o;

  logic [31:0]  d [4];
  logic [3:0]   v;
  logic [31:0]  expq [$];
  logic [31:0]  mon_exp;
  logic [3:0]   exp_cnt;
  logic [3:0]   oh;
  int           total = 0;
  int           bad = 0;

  sw_alloc_rr #(.NUM_IN(4), .DATA_W(32), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_o      (fifo_wr_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .drop_o         (drop_o),
    .pkt_cnt_o      (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fl(input logic [1:0] t, input int src, input int seq);
    return {t, src[5:0], seq[23:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] f);
    expq.push_back(f);
    if (f[31:30] == TL) exp_cnt = exp_cnt + 4'd1;
  endtask

  // Drive at posedge+1, return at posedge+3 for inline checks.
  task automatic cycle(input logic f);
    @(posedge clk);
    #1;
    valid_i     = v;
    data_i      = {d[3], d[2], d[1], d[0]};
    fifo_full_i = f;
    #2;
  endtask

  // Monitor: every write must match the queue head; idle write data must be zero.
  always @(negedge clk) begin
    total++;
    if (fifo_wr_o) begin
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected actual=%h required=none @%0t", fifo_wr_data_o, $time);
      end else begin
        mon_exp = expq.pop_front();
        if (fifo_wr_data_o !== mon_exp) begin
          bad++;
          $display("FAIL wr_data actual=%h required=%h @%0t", fifo_wr_data_o, mon_exp, $time);
        end
      end
    end else if (fifo_wr_data_o !== 32'd0) begin
      bad++;
      $display("FAIL wr_data_idle actual=%h required=0 @%0t", fifo_wr_data_o, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seqn [4];
    int order [6];
    int w;
    order = '{0, 1, 2, 3, 0, 1};
    seqn  = '{0, 0, 0, 0};
    valid_i = '0; data_i = '0; fifo_full_i = 1'b0;
    d = '{default: 32'd0};
    exp_cnt = '0;

    // Reset: a valid head must not be accepted while rst is high.
    v = 4'b0001; d[0] = fl(HD, 0, 0);
    cycle(1'b0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_wr", 32'(fifo_wr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_cnt", 32'(pkt_cnt_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
    v = 4'b0000;
    cycle(1'b0);
    rst = 1'b0;

    // Single packet on input 2.
    v = 4'b0100; d[2] = fl(HD, 2, 1);
    cycle(1'b0);
    chk("t1_ready_h", 32'(ready_o), 32'b0100);
    chk("t1_busy_h", 32'(busy_o), 32'd0);
    push(d[2]);
    d[2] = fl(BD, 2, 2);
    cycle(1'b0);
    chk("t1_ready_b", 32'(ready_o), 32'b0100);
    chk("t1_busy_b", 32'(busy_o), 32'd1);
    chk("t1_owner", 32'(owner_o), 32'd2);
    push(d[2]);
    d[2] = fl(TL, 2, 3);
    cycle(1'b0);
    chk("t1_busy_t", 32'(busy_o), 32'd1);
    push(d[2]);
    v = 4'b0000;
    cycle(1'b0);
    chk("t1_busy_end", 32'(busy_o), 32'd0);
    chk("t1_cnt", 32'(pkt_cnt_o), 32'd1);

    // Round robin from a fresh reset: rr_ptr would otherwise favour input 3.
    rst = 1'b1;
    exp_cnt = '0;
    cycle(1'b0);
    rst = 1'b0;
    v = 4'b1111;
    for (int p = 0; p < 6; p++) begin
      w = order[p];
      for (int i = 0; i < 4; i++) d[i] = fl(HD, i, seqn[i]);
      cycle(1'b0);
      oh = 4'(1 << w);
      chk("t2_grant", 32'(ready_o), 32'(oh));
      push(d[w]);
      d[w] = fl(TL, w, seqn[w] + 1);
      cycle(1'b0);
      chk("t2_owner", 32'(owner_o), 32'(w));
      chk("t2_ready_t", 32'(ready_o), 32'(oh));
      push(d[w]);
      seqn[w] += 2;
    end

    // Backpressure mid-packet on input 1 while input 3 waits with a head.
    v = 4'b0010; d[1] = fl(HD, 1, 0);
    cycle(1'b0);
    chk("t3_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));
    chk("t3_ready_h", 32'(ready_o), 32'b0010);
    push(d[1]);
    v = 4'b1010; d[1] = fl(BD, 1, 1); d[3] = fl(HD, 3, 0);
    cycle(1'b0);
    chk("t3_ready_b1", 32'(ready_o), 32'b0010);
    push(d[1]);
    d[1] = fl(BD, 1, 2);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      chk("t3_full_ready", 32'(ready_o), 32'd0);
      chk("t3_full_wr", 32'(fifo_wr_o), 32'd0);
    end
    cycle(1'b0);
    chk("t3_ready_b2", 32'(ready_o), 32'b0010);
    push(d[1]);
    d[1] = fl(TL, 1, 3);
    cycle(1'b0);
    chk("t3_ready_t", 32'(ready_o), 32'b0010);
    push(d[1]);
    v = 4'b1000;
    cycle(1'b0);
    chk("t3_ready_h3", 32'(ready_o), 32'b1000);
    push(d[3]);
    d[3] = fl(TL, 3, 1);
    cycle(1'b0);
    push(d[3]);

    // Stray body in IDLE, then a head elsewhere beats the stray.
    v = 4'b0001; d[0] = fl(BD, 0, 9);
    cycle(1'b0);
    chk("t4_stray_ready", 32'(ready_o), 32'b0001);
    chk("t4_stray_drop", 32'(drop_o), 32'd1);
    chk("t4_stray_wr", 32'(fifo_wr_o), 32'd0);
    v = 4'b0101; d[0] = fl(BD, 0, 10); d[2] = fl(HD, 2, 5);
    cycle(1'b0);
    chk("t4_head_ready", 32'(ready_o), 32'b0100);
    chk("t4_head_drop", 32'(drop_o), 32'd0);
    push(d[2]);
    d[2] = fl(TL, 2, 6);
    cycle(1'b0);
    chk("t4_tail_ready", 32'(ready_o), 32'b0100);
    push(d[2]);
    v = 4'b0001;
    cycle(1'b0);
    chk("t4_stray2_drop", 32'(drop_o), 32'd1);

    // Asynchronous reset while locked to input 3.
    v = 4'b1000; d[3] = fl(HD, 3, 7);
    cycle(1'b0);
    chk("t5_ready_h", 32'(ready_o), 32'b1000);
    push(d[3]);
    d[3] = fl(BD, 3, 8);
    cycle(1'b0);
    chk("t5_busy", 32'(busy_o), 32'd1);
    push(d[3]);
    d[3] = fl(BD, 3, 9);
    cycle(1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_owner", 32'(owner_o), 32'd0);
    chk("t5_rst_ready", 32'(ready_o), 32'd0);
    chk("t5_rst_wr", 32'(fifo_wr_o), 32'd0);
    chk("t5_rst_cnt", 32'(pkt_cnt_o), 32'd0);
    exp_cnt = '0;
    v = 4'b0000;
    cycle(1'b0);
    rst = 1'b0;
    v = 4'b1000;
    cycle(1'b0);
    chk("t5_drop_b", 32'(drop_o), 32'd1);
    chk("t5_drop_ready", 32'(ready_o), 32'b1000);
    d[3] = fl(TL, 3, 10);
    cycle(1'b0);
    chk("t5_drop_t", 32'(drop_o), 32'd1);
    v = 4'b0101; d[0] = fl(HD, 0, 1); d[2] = fl(HD, 2, 1);
    cycle(1'b0);
    chk("t5_grant0", 32'(ready_o), 32'b0001);
    chk("t5_nodrop", 32'(drop_o), 32'd0);
    push(d[0]);
    v = 4'b0001; d[0] = fl(TL, 0, 2);
    cycle(1'b0);
    chk("t5_owner", 32'(owner_o), 32'd0);
    push(d[0]);

    // Counter wrap: 16 more packets bring the 4-bit count to 17 mod 16.
    for (int k = 0; k < 16; k++) begin
      w = k % 4;
      oh = 4'(1 << w);
      v = oh; d[w] = fl(HD, w, 2 * k);
      cycle(1'b0);
      chk("t6_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));
      chk("t6_ready", 32'(ready_o), 32'(oh));
      push(d[w]);
      d[w] = fl(TL, w, 2 * k + 1);
      cycle(1'b0);
      push(d[w]);
    end
    v = 4'b0000;
    cycle(1'b0);
    chk("t6_wrap", 32'(pkt_cnt_o), 32'd1);
    cycle(1'b0);
    chk("q_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
